// File: rtl/reg_file_read_stage.sv
// Read side of the 31 x 64-bit register file: operand fetch, busy scoreboard, registered response.
// Optional same-cycle writeback bypass enabled by defining REG_READ_BYPASS_EN.
module reg_file_read_stage #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREGS = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [(NREGS-1)*WIDTH-1:0]   x_flat,
    input  logic                         wr_en,
    input  logic [4:0]                   wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [4:0]                   req_rs1,
    input  logic [4:0]                   req_rs2,
    input  logic [4:0]                   req_rd,
    input  logic                         req_rd_en,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_rs1_data,
    output logic [WIDTH-1:0]             rsp_rs2_data,
    output logic [NREGS-1:0]             busy
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_live;
    logic             rs1_fwd, rs2_fwd;
    logic             rs1_haz, rs2_haz, waw_haz;
    logic             accept;
    logic [WIDTH-1:0] rs1_val, rs2_val;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        regs[0] = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            regs[i] = x_flat[(i-1)*WIDTH +: WIDTH];
        end
    end

    assign wr_live = wr_en && (wr_addr != 5'd0);
    assign rs1_fwd = wr_live && (wr_addr == req_rs1);
    assign rs2_fwd = wr_live && (wr_addr == req_rs2);

`ifdef REG_READ_BYPASS_EN
    // A writeback landing this cycle satisfies the source even if it is still marked busy.
    assign rs1_haz = (req_rs1 != 5'd0) && busy[req_rs1] && !rs1_fwd;
    assign rs2_haz = (req_rs2 != 5'd0) && busy[req_rs2] && !rs2_fwd;
    assign rs1_val = rs1_fwd ? wr_data : regs[req_rs1];
    assign rs2_val = rs2_fwd ? wr_data : regs[req_rs2];
`else
    assign rs1_haz = (req_rs1 != 5'd0) && (busy[req_rs1] || rs1_fwd);
    assign rs2_haz = (req_rs2 != 5'd0) && (busy[req_rs2] || rs2_fwd);
    assign rs1_val = regs[req_rs1];
    assign rs2_val = regs[req_rs2];
`endif

    assign waw_haz   = req_rd_en && (req_rd != 5'd0) && busy[req_rd];
    assign req_ready = !(rs1_haz || rs2_haz || waw_haz) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Clear first so a same-cycle set on the same index wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_live) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (accept && req_rd_en && (req_rd != 5'd0)) begin
            busy_nxt[req_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
        end else if (accept) begin
            rsp_valid    <= 1'b1;
            rsp_rs1_data <= (req_rs1 == 5'd0) ? '0 : rs1_val;
            rsp_rs2_data <= (req_rs2 == 5'd0) ? '0 : rs2_val;
        end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_read_stage.sv
// Self-checking bench for reg_file_read_stage: directed scenarios plus randomized traffic
// compared every cycle against an array-based model of the register file and scoreboard.
module tb_reg_file_read_stage;

    localparam int unsigned W = 64;
    localparam int unsigned N = 32;
`ifdef REG_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [(N-1)*W-1:0] x_flat;
    logic             wr_en = 1'b0;
    logic [4:0]       wr_addr = '0;
    logic [W-1:0]     wr_data = '0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_rs1 = '0, req_rs2 = '0, req_rd = '0;
    logic             req_rd_en = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [W-1:0]     rsp_rs1_data, rsp_rs2_data;
    logic [N-1:0]     busy;

    int vectors = 0;
    int miscompares = 0;

    reg_file_read_stage #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .rst_n(rst_n), .x_flat(x_flat),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rd_en(req_rd_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Flop file that the DUT reads through x_flat; x0 does not exist.
    logic [W-1:0] regs [N] = '{default: '0};
    always @(posedge clk) begin
        if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
    end
    always_comb begin
        for (int i = 1; i < int'(N); i++) x_flat[(i-1)*W +: W] = regs[i];
    end

    // Behavioural model state
    logic [31:0]  mbusy = '0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_d1 = '0, exp_d2 = '0;

    function automatic logic m_src_haz(input logic [4:0] s);
        logic fwd;
        fwd = wr_en && (wr_addr == s);
        if (s == 5'd0) return 1'b0;
        if (BYP) return mbusy[s] && !fwd;
        return mbusy[s] || fwd;
    endfunction

    function automatic logic m_ready();
        logic haz;
        haz = m_src_haz(req_rs1) || m_src_haz(req_rs2) ||
              (req_rd_en && req_rd != 5'd0 && mbusy[req_rd]);
        return !haz && (!exp_valid || rsp_ready);
    endfunction

    function automatic logic [W-1:0] m_operand(input logic [4:0] s);
        if (s == 5'd0) return '0;
        if (BYP && wr_en && wr_addr == s) return wr_data;
        return regs[s];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic        acc;
        logic [31:0] nb;
        if (!rst_n) begin
            mbusy     <= '0;
            exp_valid <= 1'b0;
            exp_d1    <= '0;
            exp_d2    <= '0;
        end else begin
            acc = req_valid && m_ready();
            nb  = mbusy;
            if (wr_en) nb[wr_addr] = 1'b0;
            if (acc && req_rd_en) nb[req_rd] = 1'b1;
            nb[0] = 1'b0;
            mbusy <= nb;
            if (acc) begin
                exp_valid <= 1'b1;
                exp_d1    <= m_operand(req_rs1);
                exp_d2    <= m_operand(req_rs2);
            end else if (rsp_ready) begin
                exp_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready", {63'd0, req_ready}, {63'd0, m_ready()});
            check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_valid});
            if (exp_valid) begin
                check("rs1_data", rsp_rs1_data, exp_d1);
                check("rs2_data", rsp_rs2_data, exp_d2);
            end
            check("busy", {32'd0, busy}, {32'd0, mbusy});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic rden);
        req_valid = 1'b1; req_rs1 = r1; req_rs2 = r2; req_rd = rd; req_rd_en = rden;
    endtask

    initial begin
        #1;
        check("reset_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_d1", rsp_rs1_data, 64'd0);
        check("reset_d2", rsp_rs2_data, 64'd0);
        check("reset_busy", {32'd0, busy}, 64'd0);
        #11 rst_n = 1'b1;
        cyc();

        // Preload x5 / x7 through writebacks
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1111; cyc();
        wr_addr = 5'd7; wr_data = 64'h2222; cyc();
        wr_en = 1'b0;

        req(5'd5, 5'd7, 5'd0, 1'b0);
        #3 check("basic_ready", {63'd0, req_ready}, 64'd1);
        cyc();
        req_valid = 1'b0;
        check("basic_valid", {63'd0, rsp_valid}, 64'd1);
        check("basic_d1", rsp_rs1_data, 64'h1111);
        check("basic_d2", rsp_rs2_data, 64'h2222);

        req(5'd0, 5'd0, 5'd0, 1'b0);
        cyc();
        req_valid = 1'b0;
        check("x0_d1", rsp_rs1_data, 64'd0);
        check("x0_d2", rsp_rs2_data, 64'd0);

        // RAW on x3
        req(5'd0, 5'd0, 5'd3, 1'b1);
        cyc();
        req(5'd3, 5'd0, 5'd0, 1'b0);
        #3 check("raw_busy3", {63'd0, busy[3]}, 64'd1);
        check("raw_stall", {63'd0, req_ready}, 64'd0);
        cyc();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hABCD;
        #3 check("raw_wb_ready", {63'd0, req_ready}, {63'd0, BYP});
        cyc();
        wr_en = 1'b0;
        if (!BYP) begin
            #3 check("raw_next_ready", {63'd0, req_ready}, 64'd1);
            cyc();
        end
        req_valid = 1'b0;
        check("raw_d1", rsp_rs1_data, 64'hABCD);

        // Back-pressure
        req(5'd5, 5'd7, 5'd0, 1'b0);
        cyc();
        rsp_ready = 1'b0;
        req(5'd7, 5'd5, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #3 check("bp_ready", {63'd0, req_ready}, 64'd0);
            cyc();
            check("bp_hold_d1", rsp_rs1_data, 64'h1111);
            check("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
        end
        rsp_ready = 1'b1;
        #3 check("bp_release_ready", {63'd0, req_ready}, 64'd1);
        cyc();
        req_valid = 1'b0;
        check("bp_new_d1", rsp_rs1_data, 64'h2222);
        check("bp_new_d2", rsp_rs2_data, 64'h1111);

        // Same-cycle set and clear on x9, then WAW
        req(5'd0, 5'd0, 5'd9, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
        cyc();
        wr_en = 1'b0;
        check("setwins_busy9", {63'd0, busy[9]}, 64'd1);
        #3 check("waw_stall", {63'd0, req_ready}, 64'd0);
        cyc();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h9A;
        #3 check("waw_wb_stall", {63'd0, req_ready}, 64'd0);
        cyc();
        wr_en = 1'b0;
        #3 check("waw_release", {63'd0, req_ready}, 64'd1);
        cyc();
        req_valid = 1'b0;
        check("waw_busy9", {63'd0, busy[9]}, 64'd1);

        // Asynchronous reset with a held response and busy[4]
        req(5'd0, 5'd0, 5'd4, 1'b1);
        cyc();
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("pre_rst_busy4", {63'd0, busy[4]}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", {63'd0, rsp_valid}, 64'd0);
        check("async_busy", {32'd0, busy}, 64'd0);
        check("async_d1", rsp_rs1_data, 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Randomized traffic over a small index range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            cyc();
            req_valid = ($urandom_range(0, 9) < 7);
            req_rs1   = 5'($urandom_range(0, 7));
            req_rs2   = 5'($urandom_range(0, 7));
            req_rd    = 5'($urandom_range(0, 7));
            req_rd_en = $urandom_range(0, 1) == 1;
            wr_en     = ($urandom_range(0, 9) < 4);
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        req_valid = 1'b0; wr_en = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
